// File: rtl/contra_pkg.sv
// Shared types and default constants for the enemy/bullet game blocks.
// Also holds the saturating score adder.
package contra_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } enemy_state_t;

  localparam int ENEMY_HEALTH_DEF = 3;
  localparam int FLASH_FRAMES_DEF = 8;
  localparam int DEAD_FRAMES_DEF  = 60;
  localparam int KILL_POINTS_DEF  = 100;

  // A carry out of the 17-bit sum pins the result at the top of the range.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the asynchronous VS into the pixel-clock domain and emits a
// registered one-cycle frame tick, three clocks after the VS rise.
module vs_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vs_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, prev_q, tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= vs_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/enemy_hit_tracker.sv
// Bullet/enemy overlap detection, enemy health and hit/death/respawn FSM,
// and score accumulation, all advanced once per frame on the VS tick.
module enemy_hit_tracker
  import contra_pkg::*;
#(
  parameter int ENEMY_HEALTH = ENEMY_HEALTH_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int DEAD_FRAMES  = DEAD_FRAMES_DEF,
  parameter int RESPAWN      = 1,
  parameter int KILL_POINTS  = KILL_POINTS_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         VS,
  input  logic         blank_n,
  input  logic         bullet_on,
  input  logic         enemy_on,
  output logic         collision,
  output logic         enemy_visible,
  output logic         enemy_alive,
  output logic [3:0]   health,
  output logic [15:0]  score,
  output enemy_state_t dbg_state
);

  logic         frame_tick;
  enemy_state_t state_q, state_d;
  logic [3:0]   health_q, health_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [15:0]  score_q, score_d;
  logic         coll_q, coll_d;
  logic         hit_q, hit_d;
  logic         vis_q, vis_d;
  logic         alive_q, alive_d;

  vs_edge_sync u_vs_sync (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .vs_i   (VS),
    .tick_o (frame_tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ALIVE;
      health_q <= 4'(ENEMY_HEALTH);
      cnt_q    <= 8'd0;
      score_q  <= 16'd0;
      coll_q   <= 1'b0;
      hit_q    <= 1'b0;
      vis_q    <= 1'b1;
      alive_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      coll_q   <= coll_d;
      hit_q    <= hit_d;
      vis_q    <= vis_d;
      alive_q  <= alive_d;
    end
  end

  // The tick clears the latch even if an overlap lands on the same cycle.
  always_comb begin
    hit_d    = frame_tick ? 1'b0
             : (hit_q | (bullet_on & enemy_on & blank_n & (state_q == ALIVE)));
    coll_d   = frame_tick ? hit_q : coll_q;
    state_d  = state_q;
    health_d = health_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    if (frame_tick) begin
      case (state_q)
        ALIVE: begin
          if (hit_q) begin
            if (health_q > 4'd1) begin
              health_d = health_q - 4'd1;
              state_d  = HIT;
              cnt_d    = 8'(FLASH_FRAMES - 1);
            end else begin
              health_d = 4'd0;
              state_d  = DEAD;
              cnt_d    = 8'(DEAD_FRAMES - 1);
              score_d  = sat_add16(score_q, 16'(KILL_POINTS));
            end
          end
        end
        HIT: begin
          if (cnt_q == 8'd0) state_d = ALIVE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        DEAD: begin
          if ((RESPAWN != 0) && (cnt_q == 8'd0)) begin
            state_d  = ALIVE;
            health_d = 4'(ENEMY_HEALTH);
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  // Sprite gating is computed from next state so the outputs stay registered.
  always_comb begin
    vis_d   = 1'b0;
    alive_d = (state_d != DEAD);
    case (state_d)
      ALIVE:   vis_d = 1'b1;
      HIT:     vis_d = cnt_d[1];
      default: vis_d = 1'b0;
    endcase
  end

  assign collision     = coll_q;
  assign enemy_visible = vis_q;
  assign enemy_alive   = alive_q;
  assign health        = health_q;
  assign score         = score_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Frame-level bench for enemy_hit_tracker: three differently parameterised
// instances share one stimulus stream and are compared against a frame model.
module tb_enemy_hit_tracker;
  import contra_pkg::*;

  localparam int ND  = 3;
  localparam int PIX = 40;
  localparam int P_H[ND]  = '{3, 1, 2};
  localparam int P_FL[ND] = '{8, 2, 3};
  localparam int P_DF[ND] = '{60, 2, 5};
  localparam int P_RS[ND] = '{1, 1, 0};
  localparam int P_KP[ND] = '{100, 32'h7FE0, 100};

  logic clk = 1'b0;
  logic Reset_n, VS, blank_n, bullet_on, enemy_on;
  logic         coll[ND], vis[ND], alive[ND];
  logic [3:0]   hlth[ND];
  logic [15:0]  scr[ND];
  enemy_state_t st[ND];
  logic [24:0]  obs[ND];

  int n_checks = 0;
  int n_fail   = 0;

  enemy_state_t m_state[ND];
  int m_health[ND], m_cnt[ND], m_score[ND];
  logic m_coll[ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    enemy_hit_tracker #(
      .ENEMY_HEALTH (P_H[g]),
      .FLASH_FRAMES (P_FL[g]),
      .DEAD_FRAMES  (P_DF[g]),
      .RESPAWN      (P_RS[g]),
      .KILL_POINTS  (P_KP[g])
    ) dut (
      .Clk           (clk),
      .Reset_n       (Reset_n),
      .VS            (VS),
      .blank_n       (blank_n),
      .bullet_on     (bullet_on),
      .enemy_on      (enemy_on),
      .collision     (coll[g]),
      .enemy_visible (vis[g]),
      .enemy_alive   (alive[g]),
      .health        (hlth[g]),
      .score         (scr[g]),
      .dbg_state     (st[g])
    );
    assign obs[g] = {coll[g], vis[g], alive[g], st[g], hlth[g], scr[g]};
  end

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_state[d] = ALIVE; m_health[d] = P_H[d]; m_cnt[d] = 0;
      m_score[d] = 0;     m_coll[d]   = 1'b0;
    end
  endtask

  // One frame boundary: a hit counts only if the enemy was ALIVE all frame.
  task automatic model_tick(input bit overlap);
    bit hit;
    for (int d = 0; d < ND; d++) begin
      hit = overlap && (m_state[d] == ALIVE);
      m_coll[d] = hit;
      case (m_state[d])
        ALIVE: if (hit) begin
          if (m_health[d] > 1) begin
            m_health[d]--; m_state[d] = HIT; m_cnt[d] = P_FL[d] - 1;
          end else begin
            m_health[d] = 0; m_state[d] = DEAD; m_cnt[d] = P_DF[d] - 1;
            m_score[d] = (m_score[d] + P_KP[d] > 65535) ? 65535 : m_score[d] + P_KP[d];
          end
        end
        HIT: if (m_cnt[d] == 0) m_state[d] = ALIVE; else m_cnt[d]--;
        default: begin
          if (P_RS[d] != 0 && m_cnt[d] == 0) begin
            m_state[d] = ALIVE; m_health[d] = P_H[d];
          end else if (m_cnt[d] > 0) m_cnt[d]--;
        end
      endcase
    end
  endtask

  function automatic logic [24:0] exp_vec(input int d);
    logic v;
    v = (m_state[d] == ALIVE) ? 1'b1 : (m_state[d] == HIT) ? ((m_cnt[d] & 2) != 0) : 1'b0;
    return {m_coll[d], v, m_state[d] != DEAD, m_state[d], 4'(m_health[d]), 16'(m_score[d])};
  endfunction

  // Visible pixels with random single-sprite noise, then a VS rise.
  task automatic run_frame(input int n_ovl, input bit blanked, input bit tick_ovl);
    int start;
    start = (n_ovl > 0) ? $urandom_range(0, PIX - n_ovl) : PIX;
    VS = 1'b0;
    for (int i = 0; i < PIX; i++) begin
      @(negedge clk);
      if (i >= start && i < start + n_ovl) begin
        bullet_on = 1'b1; enemy_on = 1'b1; blank_n = !blanked;
      end else begin
        case ($urandom_range(0, 2))
          0:       {bullet_on, enemy_on} = 2'b10;
          1:       {bullet_on, enemy_on} = 2'b01;
          default: {bullet_on, enemy_on} = 2'b00;
        endcase
        blank_n = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    {bullet_on, enemy_on, blank_n} = 3'b000;
    VS = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tick_ovl && k == 3) {bullet_on, enemy_on, blank_n} = 3'b111;
      else                    {bullet_on, enemy_on, blank_n} = 3'b000;
    end
    model_tick((n_ovl > 0) && !blanked);
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (obs[d] !== exp_vec(d)) begin
        n_fail++; $display("FAIL reset_value dut%0d: got %h expected %h", d, obs[d], exp_vec(d));
      end
    end
    Reset_n = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame(0, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL reset_idle dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_single_hit();
    for (int f = 0; f < 12; f++) begin
      run_frame((f == 0) ? 10 : 0, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL single_hit dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_invulnerability();
    for (int f = 0; f < 22; f++) begin
      run_frame($urandom_range(1, 20), 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL invulnerable dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
    n_checks++;
    if (scr[0] !== 16'd100 || hlth[0] !== 4'd0 || vis[0] !== 1'b0) begin
      n_fail++; $display("FAIL kill_result: score %h health %0d visible %b, required 0064 0 0", scr[0], hlth[0], vis[0]);
    end
  endtask

  task automatic test_saturation();
    n_checks++;
    if (scr[1] !== 16'hFFFF) begin
      n_fail++; $display("FAIL score_saturate: got %h expected ffff", scr[1]);
    end
    for (int f = 0; f < 3; f++) begin
      run_frame(5, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL saturate_hold dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_respawn(input int frames, input string name);
    for (int f = 0; f < frames; f++) begin
      run_frame(0, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL %s dut%0d frame %0d: got %h expected %h", name, d, f, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_blank_and_boundary();
    for (int f = 0; f < 6; f++) begin
      if (f < 3) run_frame(12, 1'b1, 1'b0);
      else       run_frame(0, 1'b0, 1'b1);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL blank_boundary dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
    n_checks++;
    if (coll[0] !== 1'b0) begin
      n_fail++; $display("FAIL tick_overlap_dropped: collision %b required 0", coll[0]);
    end
  endtask

  task automatic test_reset_midframe();
    VS = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {bullet_on, enemy_on, blank_n} = 3'b111;
    end
    @(negedge clk);
    {bullet_on, enemy_on, blank_n} = 3'b000;
    Reset_n = 1'b0;
    @(negedge clk);
    model_reset();
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (obs[d] !== exp_vec(d)) begin
        n_fail++; $display("FAIL midframe_reset dut%0d: got %h expected %h", d, obs[d], exp_vec(d));
      end
    end
    Reset_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(0, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (obs[d] !== exp_vec(d)) begin
          n_fail++; $display("FAIL after_reset dut%0d frame %0d: got %h expected %h", d, f, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0; VS = 1'b0; blank_n = 1'b0; bullet_on = 1'b0; enemy_on = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_hit();
    test_invulnerability();
    test_saturation();
    test_respawn(62, "respawn");
    test_respawn(200, "no_respawn");
    test_blank_and_boundary();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
